// File: rtl/pupil_pkg.sv
// Shared types and sizes for the camera capture path and the pupil detector.
package pupil_pkg;
  localparam int MAX_RESOLUTION = 112;
  localparam int PIX_W          = 8;
  localparam int COL_W          = 7;
  localparam logic [COL_W-1:0] LAST_IDX = COL_W'(MAX_RESOLUTION - 1);

  typedef logic [PIX_W-1:0] pixel_t;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    DRAIN
  } cap_state_e;
endpackage

// File: rtl/line_bank_ram.sv
// One line of pixel storage: single write port, registered read port.
// Addresses past the end of the line read back as zero.
module line_bank_ram
  import pupil_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             we,
  input  logic [COL_W-1:0] wr_addr,
  input  pixel_t           wr_data,
  input  logic [COL_W-1:0] rd_addr,
  output pixel_t           rd_data
);
  pixel_t mem_q [MAX_RESOLUTION];
  pixel_t rd_data_d, rd_data_q;

  always_comb begin
    rd_data_d = '0;
    if (rd_addr <= LAST_IDX) rd_data_d = mem_q[rd_addr];
  end

  always_ff @(posedge clock) begin
    if (we) mem_q[wr_addr] <= wr_data;
    if (!reset) rd_data_q <= '0;
    else        rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;
endmodule

// File: rtl/cam_line_buffer.sv
// Ping-pong line capture between the camera and pupil_detect.
// Optional per-line minimum tracking is built when LINE_MIN_EN is defined.
//   state   | meaning
//   IDLE    | waiting for a frame start; pixels ignored
//   CAPTURE | writing pixels of rows 0..111 into alternating banks
//   DRAIN   | frame captured; waiting for the consumer to empty both banks
module cam_line_buffer
  import pupil_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             cam_frame_capture_start,
  input  logic             pix_valid,
  input  pixel_t           pix_data,
  output logic             line_valid,
  output logic [COL_W-1:0] line_number,
  input  logic             line_done,
  input  logic [COL_W-1:0] rd_addr,
  output pixel_t           rd_data,
`ifdef LINE_MIN_EN
  output pixel_t           line_min,
`endif
  output logic             frame_done,
  output logic             overflow
);
  cap_state_e state_q, state_d;
  logic [COL_W-1:0] col_q, col_d, row_q, row_d, line_number_q, line_number_d;
  logic [1:0][COL_W-1:0] tag_q, tag_d;
  logic [1:0] full_q, full_d;
  logic wr_q, wr_d, drop_q, drop_d, pres_q, pres_d, sel_q, sel_d;
  logic line_valid_q, line_valid_d, frame_done_q, frame_done_d, overflow_q, overflow_d;
  logic wr_en, wr_bank, drop_now, pick;
  logic [COL_W-1:0] wr_col;
  pixel_t rd_data0, rd_data1;
`ifdef LINE_MIN_EN
  pixel_t [1:0] min_q, min_d;
  pixel_t line_min_q, line_min_d;
`endif

  always_comb begin
    state_d       = state_q;
    col_d         = col_q;
    row_d         = row_q;
    tag_d         = tag_q;
    full_d        = full_q;
    wr_d          = wr_q;
    drop_d        = drop_q;
    pres_d        = pres_q;
    sel_d         = pres_q;
    line_valid_d  = line_valid_q;
    line_number_d = line_number_q;
    frame_done_d  = 1'b0;
    overflow_d    = overflow_q;
    wr_en         = 1'b0;
    wr_bank       = wr_q;
    wr_col        = col_q;
    pick          = 1'b0;
    drop_now      = (col_q == '0) ? full_q[wr_q] : drop_q;

    if (line_valid_q && line_done) begin
      full_d[pres_q] = 1'b0;
      line_valid_d   = 1'b0;
    end

    case (state_q)
      IDLE: ;
      CAPTURE: begin
        if (pix_valid) begin
          wr_en = !drop_now;
          if (col_q == '0) begin
            drop_d = full_q[wr_q];
            if (full_q[wr_q]) overflow_d = 1'b1;
          end
          if (col_q == LAST_IDX) begin
            col_d  = '0;
            row_d  = row_q + COL_W'(1);
            drop_d = 1'b0;
            // A dropped line keeps the same target bank: it is the oldest, so it frees first.
            if (!drop_now) begin
              full_d[wr_q] = 1'b1;
              tag_d[wr_q]  = row_q;
              wr_d         = ~wr_q;
            end
            if (row_q == LAST_IDX) state_d = DRAIN;
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end
      end
      DRAIN: begin
        if (full_q == 2'b00) begin
          frame_done_d = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (cam_frame_capture_start) begin
      state_d      = CAPTURE;
      row_d        = '0;
      full_d       = 2'b00;
      wr_d         = 1'b0;
      drop_d       = 1'b0;
      line_valid_d = 1'b0;
      frame_done_d = 1'b0;
      wr_bank      = 1'b0;
      wr_col       = '0;
      wr_en        = pix_valid;
      col_d        = pix_valid ? COL_W'(1) : '0;
    end

`ifdef LINE_MIN_EN
    min_d      = min_q;
    line_min_d = line_min_q;
    if (wr_en) begin
      if (wr_col == '0 || pix_data < min_q[wr_bank]) min_d[wr_bank] = pix_data;
    end
`endif

    // With both banks full, the next write bank is always the older line.
    if (!line_valid_q && full_d != 2'b00) begin
      pick          = (full_d == 2'b11) ? wr_d : full_d[1];
      line_valid_d  = 1'b1;
      pres_d        = pick;
      line_number_d = tag_d[pick];
`ifdef LINE_MIN_EN
      line_min_d    = min_d[pick];
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q       <= IDLE;
      col_q         <= '0;
      row_q         <= '0;
      tag_q         <= '0;
      full_q        <= 2'b00;
      wr_q          <= 1'b0;
      drop_q        <= 1'b0;
      pres_q        <= 1'b0;
      sel_q         <= 1'b0;
      line_valid_q  <= 1'b0;
      line_number_q <= '0;
      frame_done_q  <= 1'b0;
      overflow_q    <= 1'b0;
`ifdef LINE_MIN_EN
      min_q         <= {2{8'hFF}};
      line_min_q    <= 8'hFF;
`endif
    end else begin
      state_q       <= state_d;
      col_q         <= col_d;
      row_q         <= row_d;
      tag_q         <= tag_d;
      full_q        <= full_d;
      wr_q          <= wr_d;
      drop_q        <= drop_d;
      pres_q        <= pres_d;
      sel_q         <= sel_d;
      line_valid_q  <= line_valid_d;
      line_number_q <= line_number_d;
      frame_done_q  <= frame_done_d;
      overflow_q    <= overflow_d;
`ifdef LINE_MIN_EN
      min_q         <= min_d;
      line_min_q    <= line_min_d;
`endif
    end
  end

  line_bank_ram u_bank0 (
    .clock  (clock),
    .reset  (reset),
    .we     (wr_en && !wr_bank),
    .wr_addr(wr_col),
    .wr_data(pix_data),
    .rd_addr(rd_addr),
    .rd_data(rd_data0)
  );

  line_bank_ram u_bank1 (
    .clock  (clock),
    .reset  (reset),
    .we     (wr_en && wr_bank),
    .wr_addr(wr_col),
    .wr_data(pix_data),
    .rd_addr(rd_addr),
    .rd_data(rd_data1)
  );

  assign rd_data     = sel_q ? rd_data1 : rd_data0;
  assign line_valid  = line_valid_q;
  assign line_number = line_number_q;
  assign frame_done  = frame_done_q;
  assign overflow    = overflow_q;
`ifdef LINE_MIN_EN
  assign line_min    = line_min_q;
`endif
endmodule

// File: tb/tb_cam_line_buffer.sv
// Directed bench for cam_line_buffer; line_min checks build only with LINE_MIN_EN.
module tb_cam_line_buffer;
  import pupil_pkg::*;

  logic       clock = 1'b0;
  logic       reset, start, pix_valid, line_done;
  logic [7:0] pix_data;
  logic [6:0] rd_addr;
  logic       line_valid, frame_done, overflow;
  logic [6:0] line_number;
  logic [7:0] rd_data;
`ifdef LINE_MIN_EN
  logic [7:0] line_min;
`endif
  int n_chk = 0, n_pass = 0, fd_cnt = 0, fd_snap;

  always #5 clock = ~clock;

  cam_line_buffer dut (
    .clock                  (clock),
    .reset                  (reset),
    .cam_frame_capture_start(start),
    .pix_valid              (pix_valid),
    .pix_data               (pix_data),
    .line_valid             (line_valid),
    .line_number            (line_number),
    .line_done              (line_done),
    .rd_addr                (rd_addr),
    .rd_data                (rd_data),
`ifdef LINE_MIN_EN
    .line_min               (line_min),
`endif
    .frame_done             (frame_done),
    .overflow               (overflow)
  );

  always @(negedge clock) if (frame_done) fd_cnt++;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [7:0] pix_of(input int mode, input int row, input int c);
    case (mode)
      0:       return 8'(c);
      1:       return 8'((c + 50 * row) % 256);
      2:       return 8'(255 - c);
      3:       return (c == 90) ? 8'd57 : 8'd200;
      default: return 8'd255;
    endcase
  endfunction

  task automatic send_pixels(input int n, input int mode, input int row, input bit done_last);
    for (int c = 0; c < n; c++) begin
      pix_valid = 1'b1;
      pix_data  = pix_of(mode, row, c);
      line_done = done_last && (c == n - 1);
      tick();
    end
    pix_valid = 1'b0;
    line_done = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic release_line();
    line_done = 1'b1;
    tick();
    line_done = 1'b0;
  endtask

  task automatic read_at(input int a);
    rd_addr = 7'(a);
    tick();
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; pix_valid = 1'b0; line_done = 1'b0;
    pix_data = '0; rd_addr = '0;
    tick(); tick();
    reset = 1'b1;
    chk("rst_lv", line_valid, 0);
    chk("rst_ln", line_number, 0);
    chk("rst_rd", rd_data, 0);
    chk("rst_fd", frame_done, 0);
    chk("rst_ovf", overflow, 0);
`ifdef LINE_MIN_EN
    chk("rst_min", line_min, 255);
`endif

    // Ramp frame with a consumer releasing each line four cycles after it appears.
    pulse_start();
    for (int r = 0; r < MAX_RESOLUTION; r++) begin
      send_pixels(111, 0, r, 1'b0);
      if (r == 0) chk("ramp_lv_early", line_valid, 0);
      send_pixels(1, 0, r, 1'b0);
      chk("ramp_lv", line_valid, 1);
      chk("ramp_ln", line_number, r);
      read_at(37);
      chk("ramp_rd37", rd_data, 37);
      if (r == 0) begin
        read_at(120);
        chk("ramp_rd_oor", rd_data, 0);
      end
      tick();
      release_line();
      chk("ramp_lv_rel", line_valid, 0);
    end
    chk("ramp_fd0", frame_done, 0);
    tick();
    chk("ramp_fd1", frame_done, 1);
    tick();
    chk("ramp_fd2", frame_done, 0);
    chk("ramp_fd_cnt", fd_cnt, 1);
    chk("ramp_ovf", overflow, 0);

    // Stalled consumer: rows 0 and 1 held, row 2 dropped.
    pulse_start();
    send_pixels(112, 1, 0, 1'b0);
    chk("stall_lv0", line_valid, 1);
    send_pixels(112, 1, 1, 1'b0);
    chk("stall_ovf_pre", overflow, 0);
    send_pixels(112, 1, 2, 1'b0);
    chk("stall_ovf", overflow, 1);
    chk("stall_ln0", line_number, 0);
    read_at(5);
    chk("stall_rd_b0", rd_data, 5);
    release_line();
    chk("stall_lv_gap", line_valid, 0);
    tick();
    chk("stall_lv1", line_valid, 1);
    chk("stall_ln1", line_number, 1);
    tick();
    chk("stall_rd_b1", rd_data, 55);
    release_line();
    tick();
    chk("stall_empty", line_valid, 0);

    // Back-to-back: release coincides with completion of the next line.
    pulse_start();
    send_pixels(112, 0, 0, 1'b0);
    chk("b2b_ln0", line_number, 0);
    send_pixels(112, 0, 1, 1'b1);
    chk("b2b_lv_low", line_valid, 0);
    tick();
    chk("b2b_lv_high", line_valid, 1);
    chk("b2b_ln1", line_number, 1);
    release_line();

    // Mid-line restart.
    pulse_start();
    send_pixels(112, 1, 0, 1'b0); release_line();
    send_pixels(112, 1, 1, 1'b0); release_line();
    send_pixels(112, 1, 2, 1'b0);
    chk("rst3_ln2", line_number, 2);
    send_pixels(50, 1, 3, 1'b0);
    fd_snap = fd_cnt;
    pulse_start();
    chk("rst3_lv0", line_valid, 0);
    send_pixels(112, 2, 0, 1'b0);
    chk("rst3_lv", line_valid, 1);
    chk("rst3_ln", line_number, 0);
    read_at(0);
    chk("rst3_rd0", rd_data, 255);
    read_at(111);
    chk("rst3_rd111", rd_data, 144);
    chk("rst3_no_fd", fd_cnt, fd_snap);

    // Reset mid-line while a line is presented.
    send_pixels(20, 0, 1, 1'b0);
    chk("mid_ovf_sticky", overflow, 1);
    chk("mid_lv", line_valid, 1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("mid_rst_lv", line_valid, 0);
    chk("mid_rst_ln", line_number, 0);
    chk("mid_rst_rd", rd_data, 0);
    chk("mid_rst_fd", frame_done, 0);
    chk("mid_rst_ovf", overflow, 0);
`ifdef LINE_MIN_EN
    chk("mid_rst_min", line_min, 255);
`endif
    send_pixels(112, 0, 0, 1'b0);
    tick();
    chk("idle_ignore", line_valid, 0);
    pulse_start();
    send_pixels(112, 0, 0, 1'b0);
    chk("post_rst_lv", line_valid, 1);
    chk("post_rst_ln", line_number, 0);
    read_at(37);
    chk("post_rst_rd", rd_data, 37);
    release_line();

`ifdef LINE_MIN_EN
    pulse_start();
    send_pixels(112, 3, 0, 1'b0);
    chk("min_lv", line_valid, 1);
    chk("min_57", line_min, 57);
    release_line();
    send_pixels(112, 4, 1, 1'b0);
    chk("min_ln", line_number, 1);
    chk("min_255", line_min, 255);
    release_line();
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/cam_line_buffer.md
# cam_line_buffer

Ping-pong line capture stage between the inward-facing camera pixel interface and `pupil_detect`. Collects one 8-bit grayscale pixel per `pix_valid` strobe into one of two 112-pixel line banks. Hands each completed line to the pupil detector through a valid/done handshake and a registered random-access read port. Capture continues into the other bank while the detector scans, so the detector never sees a partially written line.

## Interface
- `MAX_RESOLUTION`, 112: pixels per line and lines per frame.
- `PIX_W`, 8: pixel width (black = 0, white = 255).
- `clock`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `cam_frame_capture_start`  in  1  one-cycle pulse; starts a new frame.
- `pix_valid`  in  1  one pixel present on `pix_data` this cycle.
- `pix_data`  in  8  grayscale pixel, raster order.
- `line_valid`  out  1  a completed line is readable; held until `line_done`.
- `line_number`  out  7  row index (0..111) of the presented line.
- `line_done`  in  1  consumer pulse; releases the presented bank.
- `rd_addr`  in  7  column to read (0..111) from the presented bank.
- `rd_data`  out  8  pixel at `rd_addr`, registered.
- `line_min`  out  8  minimum pixel of the presented line (only with `LINE_MIN_EN`).
- `frame_done`  out  1  one-cycle pulse after the last line of a frame is released.
- `overflow`  out  1  sticky; a line was dropped because both banks were full.

## Operation
- Reset values: `line_valid`=0, `line_number`=0, `rd_data`=0, `frame_done`=0, `overflow`=0, `line_min`=8'hFF. Both banks are marked empty. State is IDLE.
- States:
  - IDLE: `pix_valid` is ignored. `cam_frame_capture_start` moves to CAPTURE with col=0, row=0, write bank=0.
  - CAPTURE: each `pix_valid` writes to `bank[wr][col]` and increments col.
    - At col=111 the bank is marked full, tagged with row, col wraps to 0, wr toggles, and row increments.
    - After row 111 is written, moves to DRAIN.
  - DRAIN: waits until both banks are empty, pulses `frame_done`, then goes to IDLE.
- Presentation: if no bank is presented and any bank is full, the oldest full bank is presented and `line_valid` rises. `line_done` clears that bank's full flag and drops `line_valid` on the next cycle.
- Overflow: if the write bank is still full when col=0 of a new line begins, every pixel of that line is discarded. The dropped line still advances row, and `overflow` is set; only reset clears it.
- `cam_frame_capture_start` in CAPTURE or DRAIN:
  - discards any partial line, empties both banks, and deasserts `line_valid`;
  - restarts at col=0, row=0 in CAPTURE;
  - does not pulse `frame_done`.
- `line_done` while `line_valid`=0 is ignored.
- Out-of-range `rd_addr` (>111) returns 0.

## Timing
- Last pixel of a line on cycle N sets `line_valid` at N+1 if the consumer is idle.
- `rd_data` is valid one cycle after `rd_addr`, i.e. one-cycle read latency.
- `line_done` on cycle N gives `line_valid`=0 at N+1. If the other bank is already full, `line_valid`=1 again at N+2 with the new `line_number`.
- Simultaneous last-pixel write and `line_done`: both take effect. The just-completed bank is presented two cycles later.
- Simultaneous `pix_valid` and `cam_frame_capture_start`: the pixel is written as col 0 of the new frame.
- A reset assertion mid-frame returns to the reset values on the next edge, regardless of the handshake.
- Sustained throughput is one pixel per clock.

## Configuration
- `LINE_MIN_EN` defined: a running minimum is tracked per bank during writes, starting at 8'hFF for each new line. `line_min` shows the presented bank's minimum, updating in the same cycle as `line_valid`.
- `LINE_MIN_EN` undefined: the `line_min` port and its logic are absent.

## Structure
- Shared package `pupil_pkg`:
  - `MAX_RESOLUTION`, `PIX_W`, `COL_W`=7;
  - the state enum (IDLE, CAPTURE, DRAIN);
  - a `pixel_t` typedef.
  `pupil_detect` uses the same package.
- One sub-module, `line_bank_ram`: a 112x8 memory with one write port and one registered read port, instantiated twice. Bank select muxes `rd_data`.

## Test plan
- Ramp frame: pixel = col, consumer asserts `line_done` 4 cycles after each `line_valid` -> 112 lines, `line_number` 0..111 in order, `rd_addr`=37 returns 37, one `frame_done` pulse, `overflow`=0.
- Stalled consumer: never asserts `line_done` for 3 lines -> rows 0 and 1 held, row 2 dropped, `overflow`=1. After `line_done` twice, `line_number` goes 0 then 1.
- Back-to-back: `line_done` on the cycle the second line completes -> `line_valid` low for exactly one cycle, then `line_number`=1.
- Mid-line restart: `cam_frame_capture_start` after 50 pixels of row 3 -> `line_valid`=0 next cycle, no `frame_done`, the next 112 pixels present as `line_number`=0.
- Reset: `reset` low for 1 cycle mid-line with `line_valid`=1 -> all outputs at reset values and state IDLE; `pix_valid` is ignored until the next start pulse.
- `LINE_MIN_EN`: line of all 200 with pixel 57 at col 90 -> `line_min`=57. Next line all 255 -> `line_min`=255.
